// File: rtl/step_input_pkg.sv
// Shared types and board-level constants for the push-button / run-switch input conditioner.
package step_input_pkg;

  typedef enum logic [2:0] {
    LOCKOUT     = 3'd0,
    IDLE        = 3'd1,
    PRESS_CHK   = 3'd2,
    HELD        = 3'd3,
    RELEASE_CHK = 3'd4
  } deb_state_e;

  localparam int unsigned CLK50_HZ      = 32'd50_000_000;
  localparam int unsigned DEBOUNCE_20MS = CLK50_HZ / 32'd50;
  localparam int unsigned RUN_2HZ       = CLK50_HZ / 32'd2;

  // Accepted key level: the key counts as down until its release is confirmed.
  function automatic logic is_level(input deb_state_e s);
    return (s == HELD) || (s == RELEASE_CHK);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes one active-low raw key and debounces it into a level and a one-cycle press pulse.
module key_debounce
  import step_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int unsigned SYNC_STAGES     = 32'd2
) (
  input  logic clk50,
  input  logic reset,
  input  logic rawKey,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 32'd1) ? $clog2(DEBOUNCE_CYCLES) : 32'd1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'd1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pressed_s;
  deb_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q;
  logic                   rise_q, rise_d;

  // Raw key synchronizer; resets to "released" so a held key must first be seen released.
  always_ff @(posedge clk50) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rawKey};
    end
  end

  assign pressed_s = ~sync_q[SYNC_STAGES-1];

  // Debounce next-state: every state change restarts the hold counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    case (state_q)
      LOCKOUT: begin
        if (pressed_s) begin
          cnt_d = {CW{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (pressed_s) begin
          state_d = PRESS_CHK;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = {CW{1'b0}};
        end
      end
      PRESS_CHK: begin
        if (!pressed_s) begin
          state_d = IDLE;
          cnt_d   = {CW{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = {CW{1'b0}};
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!pressed_s) begin
          state_d = RELEASE_CHK;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = {CW{1'b0}};
        end
      end
      RELEASE_CHK: begin
        if (pressed_s) begin
          state_d = HELD;
          cnt_d   = {CW{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = LOCKOUT;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q <= LOCKOUT;
      cnt_q   <= {CW{1'b0}};
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= is_level(state_d);
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/step_input.sv
// Turns raw DE-board keys and the run switch into the processor step enable, peek level and run flag.
module step_input
  import step_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int unsigned RUN_DIV         = RUN_2HZ,
  parameter int unsigned SYNC_STAGES     = 32'd2
) (
  input  logic clk50,
  input  logic reset,
  input  logic stepKey,
  input  logic peekKey,
  input  logic runMode,
  output logic stepEn,
  output logic peek,
  output logic runActive
);

  localparam int unsigned DW = (RUN_DIV > 32'd1) ? $clog2(RUN_DIV) : 32'd1;
  localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 32'd1);

  logic [SYNC_STAGES-1:0] run_sync_q;
  logic                   mode_change_s;
  logic [DW-1:0]          div_q, div_d;
  logic                   step_en_q, step_en_d;
  logic                   peek_q;
  logic                   step_rise_s, step_level_s;
  logic                   peek_rise_s, peek_level_s;
  logic                   unused_ok_s;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_step_key (
    .clk50 (clk50),
    .reset (reset),
    .rawKey(stepKey),
    .level (step_level_s),
    .rise  (step_rise_s)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_peek_key (
    .clk50 (clk50),
    .reset (reset),
    .rawKey(peekKey),
    .level (peek_level_s),
    .rise  (peek_rise_s)
  );

  assign unused_ok_s = step_level_s ^ peek_rise_s;

  // Run switch synchronizer.
  always_ff @(posedge clk50) begin
    if (reset) begin
      run_sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      run_sync_q <= {run_sync_q[SYNC_STAGES-2:0], runMode};
    end
  end

  assign runActive     = run_sync_q[SYNC_STAGES-1];
  // runActive is about to flip on this edge: restart the divider alongside it.
  assign mode_change_s = run_sync_q[SYNC_STAGES-1] ^ run_sync_q[SYNC_STAGES-2];

  // Step source select: auto-run divider or the debounced step key.
  always_comb begin
    div_d     = div_q;
    step_en_d = 1'b0;
    if (mode_change_s) begin
      div_d     = {DW{1'b0}};
      step_en_d = 1'b0;
    end else if (runActive) begin
      step_en_d = (div_q == DIV_LAST);
      div_d     = (div_q == DIV_LAST) ? {DW{1'b0}} : div_q + 1'b1;
    end else begin
      div_d     = {DW{1'b0}};
      step_en_d = step_rise_s;
    end
  end

  // Divider and registered outputs.
  always_ff @(posedge clk50) begin
    if (reset) begin
      div_q     <= {DW{1'b0}};
      step_en_q <= 1'b0;
      peek_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      step_en_q <= step_en_d;
      peek_q    <= peek_level_s;
    end
  end

  assign stepEn = step_en_q;
  assign peek   = peek_q;

endmodule
